csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Machine-mode CSR file and trap sequencer for the 5-stage RV32I core.
- Sits directly downstream of the instruction decoder. It consumes csr_write/csr_read/csr_op/csr_rsrc in EX, returns the old CSR value for rd, and commits the new value at the clock edge.
- Owns the 64-bit cycle/instret counters, interrupt entry, MRET return and the WFI sleep state. Drives a PC redirect to the fetch stage.

Parameters:
- MTVEC_RESET, 32'h0001_0000, reset value of mtvec (direct mode, bits[1:0] forced 0)
- HART_ID, 32'd0, value returned for mhartid

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline hold; blocks CSR/trap/mret commits but not mcycle
- csr_read  in  1  decoder: CSR instruction in EX
- csr_write  in  1  decoder: CSR write enable
- csr_op  in  2  decoder: CSR_NOP / CSR_ASIGN / CSR_OR / CSR_AND (shared header macros)
- csr_rsrc  in  1  decoder: 0 = rs1_data source, 1 = zero-extended zimm
- csr_addr  in  12  inst[31:20]
- rs1_data  in  32  forwarded rs1
- zimm  in  5  inst[19:15]
- mret  in  1  MRET in EX
- wfi  in  1  WFI in EX
- inst_retire  in  1  one instruction retired this cycle
- trap_pc  in  32  PC of the instruction in EX (mepc on trap)
- ext_irq  in  1  external interrupt level (MEIP)
- timer_irq  in  1  timer interrupt level (MTIP)
- csr_rdata  out  32  old CSR value, to rd
- redirect  out  1  one-cycle pulse, flush and load redirect_pc
- redirect_pc  out  32  mtvec on trap, mepc on mret
- sleep  out  1  high while in WFI_SLEEP; fetch holds
- illegal_csr  out  1  csr_read to an unimplemented address

Behaviour:
- Reset (rst low, async): all outputs 0; mstatus 0 except MPP = 2'b11; mie 0; mepc 0; mcause 0; mtvec = MTVEC_RESET; counters 0; state RUN.
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] read-only 11; other bits read 0.
  - mie 0x304: MEIE bit 11, MTIE bit 7; others read 0.
  - mtvec 0x305.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mip 0x344: read-only, bit 11 = ext_irq, bit 7 = timer_irq.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - Read-only aliases 0xC00/0xC80/0xC02/0xC82.
  - mhartid 0xF14.
- Read: csr_rdata is combinational, current (pre-write) value. Unimplemented address gives 0 and illegal_csr = csr_read.
- Source: src = csr_rsrc ? {27'b0, zimm} : rs1_data.
- New value by csr_op: ASIGN → src; OR → old | src; AND → old & ~src; NOP → no write.
- Commit: at posedge when csr_write && !stall && !trap_fire. Writes to read-only or unimplemented addresses are dropped silently.
- Counters: mcycle +1 every cycle (including stall and sleep). minstret +1 when inst_retire. Both wrap 2^64 → 0. A software write to either half in the same cycle wins over the increment for the whole 64-bit counter that cycle.
- Pending: pend = {ext_irq & MEIE, timer_irq & MTIE}.
- trap_fire = MIE && |pend && !stall (state RUN or WFI_SLEEP).
- On trap_fire at posedge:
  - mepc ← trap_pc; in WFI_SLEEP, mepc ← trap_pc + 4.
  - mcause ← 32'h8000_000B if external pending, else 32'h8000_0007 (external has priority).
  - MPIE ← MIE; MIE ← 0.
  - redirect = 1 for one cycle with redirect_pc = mtvec; state → RUN.
- MRET (mret && !stall && !trap_fire): MIE ← MPIE, MPIE ← 1, redirect = 1 with redirect_pc = mepc. The trap wins if both occur in the same cycle.
- State machine RUN / WFI_SLEEP:
  - RUN → WFI_SLEEP on wfi && !stall && !trap_fire.
  - WFI_SLEEP → RUN on |pend, regardless of MIE. If MIE = 0, no trap; resume at the next instruction with no redirect.
  - sleep = (state == WFI_SLEEP).
- redirect and redirect_pc are registered: asserted in the cycle after the commit edge, low otherwise.
- Reset mid-operation: state returns to RUN, a pending redirect is cancelled, counters clear.

Test Plan:
- CSRRW 0x305 with rs1 = 0x0002_0003, then CSRRS x0 0x305 → csr_rdata 0x0002_0000; the first instruction's rd gets 0x0001_0000.
- mstatus = 0x8; CSRRCI 0x300 zimm = 8 → rd = 0x0000_1808 (MPP reads 11); next read → 0x0000_1800.
- MIE = 1, MEIE = MTIE = 1, both irqs raised together with trap_pc 0x100 → redirect_pc = mtvec, mcause 0x8000_000B, mepc 0x100, mstatus.MIE 0 / MPIE 1. Then mret → redirect_pc 0x100, MIE 1.
- mcycle written 0xFFFF_FFFF, mcycleh written 0 → after two cycles mcycleh reads 1. Set 0xFFFF_FFFF_FFFF_FFFF → wraps to 0 next cycle.
- WFI with MIE = 0, timer_irq raised 5 cycles later → sleep high 5 cycles then low, no redirect, mcause unchanged.
- CSRRW to 0x300 in the same cycle as trap_fire → write dropped, trap taken. Assert rst low mid-sleep → sleep 0, counters 0, mtvec = MTVEC_RESET.

Source files
------------

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap sequencer for the 5-stage RV32I core.
//
// Ports:
//   clk, rst                  core clock, asynchronous active-low reset
//   stall                     pipeline hold; blocks CSR/trap/mret commits, not mcycle
//   csr_read/csr_write        CSR instruction in EX / CSR write enable
//   csr_op, csr_rsrc          operation (NOP/ASIGN/OR/AND), source select (rs1 / zimm)
//   csr_addr, rs1_data, zimm  address and write sources
//   mret, wfi, inst_retire    MRET / WFI in EX, retirement strobe for minstret
//   trap_pc                   PC of the instruction in EX (captured into mepc)
//   ext_irq, timer_irq        interrupt levels (MEIP / MTIP)
//   csr_rdata                 old CSR value for rd (combinational)
//   redirect, redirect_pc     registered one-cycle flush + target (mtvec / mepc)
//   sleep                     high while in WFI sleep
//   illegal_csr               csr_read of an unimplemented address
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [1:0]  csr_op,
  input  logic        csr_rsrc,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        mret,
  input  logic        wfi,
  input  logic        inst_retire,
  input  logic [31:0] trap_pc,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        sleep,
  output logic        illegal_csr
);

  localparam logic [1:0] CSR_NOP   = 2'd0;
  localparam logic [1:0] CSR_ASIGN = 2'd1;
  localparam logic [1:0] CSR_OR    = 2'd2;
  localparam logic [1:0] CSR_AND   = 2'd3;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_WFI_SLEEP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_meie;
  logic        r_mtie;
  logic [31:2] r_mtvec;
  logic [31:2] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  logic [31:0] w_mstatus;
  logic [31:0] w_mie;
  logic [31:0] w_mip;
  logic [31:0] w_old;
  logic        w_impl;
  logic        w_writable;
  logic [31:0] w_src;
  logic [31:0] w_new;
  logic [1:0]  w_pend;
  logic        w_trap_fire;
  logic        w_mret_fire;
  logic        w_do_write;
  logic [31:2] w_trap_epc;
  logic        w_unused;

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign w_mie     = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};

  // Read mux: value before this cycle's commit, plus implemented/writable flags.
  always_comb begin
    w_old      = '0;
    w_impl     = 1'b1;
    w_writable = 1'b0;
    case (csr_addr)
      12'h300: begin w_old = w_mstatus;              w_writable = 1'b1; end
      12'h304: begin w_old = w_mie;                  w_writable = 1'b1; end
      12'h305: begin w_old = {r_mtvec, 2'b00};       w_writable = 1'b1; end
      12'h341: begin w_old = {r_mepc, 2'b00};        w_writable = 1'b1; end
      12'h342: begin w_old = r_mcause;               w_writable = 1'b1; end
      12'h344: w_old = w_mip;
      12'hB00: begin w_old = r_mcycle[31:0];         w_writable = 1'b1; end
      12'hB80: begin w_old = r_mcycle[63:32];        w_writable = 1'b1; end
      12'hB02: begin w_old = r_minstret[31:0];       w_writable = 1'b1; end
      12'hB82: begin w_old = r_minstret[63:32];      w_writable = 1'b1; end
      12'hC00: w_old = r_mcycle[31:0];
      12'hC80: w_old = r_mcycle[63:32];
      12'hC02: w_old = r_minstret[31:0];
      12'hC82: w_old = r_minstret[63:32];
      12'hF14: w_old = HART_ID;
      default: w_impl = 1'b0;
    endcase
  end

  assign w_src = csr_rsrc ? {27'b0, zimm} : rs1_data;

  always_comb begin
    w_new = w_old;
    case (csr_op)
      CSR_ASIGN: w_new = w_src;
      CSR_OR:    w_new = w_old | w_src;
      CSR_AND:   w_new = w_old & ~w_src;
      default:   w_new = w_old;
    endcase
  end

  assign w_pend      = {ext_irq & r_meie, timer_irq & r_mtie};
  assign w_trap_fire = r_mstatus_mie && (|w_pend) && !stall;
  assign w_mret_fire = mret && !stall && !w_trap_fire;
  assign w_do_write  = csr_write && !stall && !w_trap_fire && w_writable && (csr_op != CSR_NOP);

  // Trap out of WFI returns past the WFI instruction.
  assign w_trap_epc = (r_state == ST_WFI_SLEEP) ? (trap_pc[31:2] + 30'd1) : trap_pc[31:2];
  assign w_unused   = ^trap_pc[1:0];

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state. Leaving sleep depends only on pending, not on MIE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:       if (wfi && !stall && !w_trap_fire) w_state_nxt = ST_WFI_SLEEP;
      ST_WFI_SLEEP: if (w_trap_fire || (|w_pend))     w_state_nxt = ST_RUN;
      default:      w_state_nxt = ST_RUN;
    endcase
  end

  // mstatus: trap > mret > software write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (w_trap_fire) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_mret_fire) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_do_write && csr_addr == 12'h300) begin
      r_mstatus_mie  <= w_new[3];
      r_mstatus_mpie <= w_new[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meie  <= 1'b0;
      r_mtie  <= 1'b0;
      r_mtvec <= MTVEC_RESET[31:2];
    end else if (w_do_write) begin
      if (csr_addr == 12'h304) begin
        r_meie <= w_new[11];
        r_mtie <= w_new[7];
      end
      if (csr_addr == 12'h305) r_mtvec <= w_new[31:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (w_trap_fire) begin
      r_mepc   <= w_trap_epc;
      r_mcause <= w_pend[1] ? 32'h8000_000B : 32'h8000_0007;
    end else if (w_do_write) begin
      if (csr_addr == 12'h341) r_mepc   <= w_new[31:2];
      if (csr_addr == 12'h342) r_mcause <= w_new;
    end
  end

  // Counters: a write to either half replaces the whole increment that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_do_write && csr_addr == 12'hB00)      r_mcycle <= {r_mcycle[63:32], w_new};
      else if (w_do_write && csr_addr == 12'hB80) r_mcycle <= {w_new, r_mcycle[31:0]};
      else                                        r_mcycle <= r_mcycle + 64'd1;

      if (w_do_write && csr_addr == 12'hB02)      r_minstret <= {r_minstret[63:32], w_new};
      else if (w_do_write && csr_addr == 12'hB82) r_minstret <= {w_new, r_minstret[31:0]};
      else if (inst_retire)                       r_minstret <= r_minstret + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_trap_fire || w_mret_fire;
      if (w_trap_fire)      r_redirect_pc <= {r_mtvec, 2'b00};
      else if (w_mret_fire) r_redirect_pc <= {r_mepc, 2'b00};
      else                  r_redirect_pc <= '0;
    end
  end

  assign csr_rdata   = csr_read ? w_old : '0;
  assign illegal_csr = csr_read & ~w_impl;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign sleep       = (r_state == ST_WFI_SLEEP);

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] ASG = 2'd1;
  localparam logic [1:0] ORR = 2'd2;
  localparam logic [1:0] ANDN = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        csr_read;
  logic        csr_write;
  logic [1:0]  csr_op;
  logic        csr_rsrc;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        mret;
  logic        wfi;
  logic        inst_retire;
  logic [31:0] trap_pc;
  logic        ext_irq;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        sleep;
  logic        illegal_csr;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        ill;

  always #5 clk = ~clk;

  csr_unit #(.MTVEC_RESET(32'h0001_0000), .HART_ID(32'd0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .csr_read(csr_read), .csr_write(csr_write), .csr_op(csr_op), .csr_rsrc(csr_rsrc),
    .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
    .mret(mret), .wfi(wfi), .inst_retire(inst_retire), .trap_pc(trap_pc),
    .ext_irq(ext_irq), .timer_irq(timer_irq),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .sleep(sleep), .illegal_csr(illegal_csr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One CSR instruction in EX for one cycle; rd/ill sampled mid-cycle.
  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic use_z,
                     input logic [31:0] src, output logic [31:0] r, output logic il);
    @(negedge clk);
    csr_read  = 1'b1;
    csr_write = (op != NOP);
    csr_op    = op;
    csr_addr  = a;
    csr_rsrc  = use_z;
    rs1_data  = src;
    zimm      = src[4:0];
    #1;
    r  = csr_rdata;
    il = illegal_csr;
    @(posedge clk);
    #1;
    csr_read  = 1'b0;
    csr_write = 1'b0;
    csr_op    = NOP;
    csr_rsrc  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; csr_read = 1'b0; csr_write = 1'b0; csr_op = NOP;
    csr_rsrc = 1'b0; csr_addr = '0; rs1_data = '0; zimm = '0; mret = 1'b0; wfi = 1'b0;
    inst_retire = 1'b0; trap_pc = '0; ext_irq = 1'b0; timer_irq = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_sleep", 32'(sleep), 32'd0);
    chk("rst_illegal", 32'(illegal_csr), 32'd0);
    chk("rst_rdata_idle", csr_rdata, 32'd0);
    csr_read = 1'b1; csr_addr = 12'h305; #1;
    chk("rst_mtvec", csr_rdata, 32'h0001_0000);
    csr_addr = 12'h300; #1;
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    csr_read = 1'b0;
    @(negedge clk); rst = 1'b1;

    // mtvec write / read back
    csr(12'h305, ASG, 1'b0, 32'h0002_0003, rd, ill);
    chk("mtvec_old", rd, 32'h0001_0000);
    csr(12'h305, NOP, 1'b0, 32'h0, rd, ill);
    chk("mtvec_new", rd, 32'h0002_0000);
    chk("mtvec_legal", 32'(ill), 32'd0);

    // mstatus CSRRCI
    csr(12'h300, ASG, 1'b0, 32'h0000_0008, rd, ill);
    chk("mstatus_w_old", rd, 32'h0000_1800);
    csr(12'h300, ANDN, 1'b1, 32'h0000_0008, rd, ill);
    chk("mstatus_rci_old", rd, 32'h0000_1808);
    csr(12'h300, NOP, 1'b0, 32'h0, rd, ill);
    chk("mstatus_rci_new", rd, 32'h0000_1800);

    // Illegal address, mhartid, mepc masking, read-only drop
    csr(12'h123, NOP, 1'b0, 32'h0, rd, ill);
    chk("illegal_rdata", rd, 32'h0);
    chk("illegal_flag", 32'(ill), 32'd1);
    csr(12'hF14, ASG, 1'b0, 32'd5, rd, ill);
    csr(12'hF14, NOP, 1'b0, 32'h0, rd, ill);
    chk("mhartid_ro", rd, 32'd0);
    csr(12'h341, ASG, 1'b0, 32'h0000_0123, rd, ill);
    csr(12'h341, NOP, 1'b0, 32'h0, rd, ill);
    chk("mepc_mask", rd, 32'h0000_0120);

    // Stalled write is dropped
    stall = 1'b1;
    csr(12'h305, ASG, 1'b0, 32'h0003_0000, rd, ill);
    stall = 1'b0;
    csr(12'h305, NOP, 1'b0, 32'h0, rd, ill);
    chk("stall_drop", rd, 32'h0002_0000);

    // Both interrupts, external wins
    csr(12'h304, ASG, 1'b0, 32'h0000_0880, rd, ill);
    csr(12'h300, ASG, 1'b0, 32'h0000_0008, rd, ill);
    ext_irq = 1'b1; timer_irq = 1'b1; trap_pc = 32'h0000_0100;
    @(posedge clk); #1;
    ext_irq = 1'b0; timer_irq = 1'b0;
    chk("trap_redirect", 32'(redirect), 32'd1);
    chk("trap_pc_tgt", redirect_pc, 32'h0002_0000);
    @(posedge clk); #1;
    chk("trap_redirect_pulse", 32'(redirect), 32'd0);
    csr(12'h342, NOP, 1'b0, 32'h0, rd, ill);
    chk("trap_mcause_ext", rd, 32'h8000_000B);
    csr(12'h341, NOP, 1'b0, 32'h0, rd, ill);
    chk("trap_mepc", rd, 32'h0000_0100);
    csr(12'h300, NOP, 1'b0, 32'h0, rd, ill);
    chk("trap_mstatus", rd, 32'h0000_1880);

    // MRET
    @(negedge clk); mret = 1'b1;
    @(posedge clk); #1; mret = 1'b0;
    chk("mret_redirect", 32'(redirect), 32'd1);
    chk("mret_pc_tgt", redirect_pc, 32'h0000_0100);
    csr(12'h300, NOP, 1'b0, 32'h0, rd, ill);
    chk("mret_mstatus", rd, 32'h0000_1888);

    // Timer-only trap
    timer_irq = 1'b1; trap_pc = 32'h0000_0204;
    @(posedge clk); #1; timer_irq = 1'b0;
    chk("ttrap_pc_tgt", redirect_pc, 32'h0002_0000);
    csr(12'h342, NOP, 1'b0, 32'h0, rd, ill);
    chk("ttrap_mcause", rd, 32'h8000_0007);
    csr(12'h341, NOP, 1'b0, 32'h0, rd, ill);
    chk("ttrap_mepc", rd, 32'h0000_0204);

    // mip reflects raw levels (MIE is 0 now, no trap)
    ext_irq = 1'b1;
    csr(12'h344, NOP, 1'b0, 32'h0, rd, ill);
    chk("mip_ext", rd, 32'h0000_0800);
    ext_irq = 1'b0;

    // mcycle carry into high half
    csr(12'hB00, ASG, 1'b0, 32'hFFFF_FFFF, rd, ill);
    csr(12'hB80, ASG, 1'b0, 32'h0, rd, ill);
    @(posedge clk); #1;
    csr(12'hB80, NOP, 1'b0, 32'h0, rd, ill);
    chk("mcycleh_carry", rd, 32'd1);
    csr(12'hC80, NOP, 1'b0, 32'h0, rd, ill);
    chk("cycleh_alias", rd, 32'd1);

    // mcycle 64-bit wrap
    csr(12'hB00, ASG, 1'b0, 32'hFFFF_FFFF, rd, ill);
    csr(12'hB80, ASG, 1'b0, 32'hFFFF_FFFF, rd, ill);
    csr(12'hB00, NOP, 1'b0, 32'h0, rd, ill);
    chk("mcycle_max", rd, 32'hFFFF_FFFF);
    csr(12'hB80, NOP, 1'b0, 32'h0, rd, ill);
    chk("mcycleh_wrap", rd, 32'h0);
    csr(12'hB00, NOP, 1'b0, 32'h0, rd, ill);
    chk("mcycle_after_wrap", rd, 32'd1);

    // minstret: write wins over a retire in the same cycle
    inst_retire = 1'b1;
    csr(12'hB02, ASG, 1'b0, 32'd10, rd, ill);
    repeat (3) @(posedge clk);
    #1; inst_retire = 1'b0;
    csr(12'hC02, NOP, 1'b0, 32'h0, rd, ill);
    chk("minstret_count", rd, 32'd13);
    csr(12'hB82, NOP, 1'b0, 32'h0, rd, ill);
    chk("minstreth", rd, 32'd0);

    // WFI with MIE = 0: wake without trap
    csr(12'h304, ASG, 1'b0, 32'h0000_0080, rd, ill);
    csr(12'h300, ASG, 1'b0, 32'h0, rd, ill);
    @(negedge clk); wfi = 1'b1;
    @(posedge clk); #1; wfi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("wfi_sleep_%0d", i), 32'(sleep), 32'd1);
      chk($sformatf("wfi_noredir_%0d", i), 32'(redirect), 32'd0);
    end
    timer_irq = 1'b1;
    @(negedge clk);
    chk("wfi_wake", 32'(sleep), 32'd0);
    chk("wfi_wake_noredir", 32'(redirect), 32'd0);
    @(negedge clk);
    chk("wfi_wake_noredir2", 32'(redirect), 32'd0);
    timer_irq = 1'b0;
    csr(12'h342, NOP, 1'b0, 32'h0, rd, ill);
    chk("wfi_mcause_kept", rd, 32'h8000_0007);

    // WFI with MIE = 1: trap, mepc = trap_pc + 4
    csr(12'h300, ASG, 1'b0, 32'h0000_0008, rd, ill);
    @(negedge clk); wfi = 1'b1;
    @(posedge clk); #1; wfi = 1'b0;
    chk("wfi2_sleep", 32'(sleep), 32'd1);
    @(negedge clk); timer_irq = 1'b1; trap_pc = 32'h0000_0300;
    @(posedge clk); #1; timer_irq = 1'b0;
    chk("wfi2_redirect", 32'(redirect), 32'd1);
    chk("wfi2_pc_tgt", redirect_pc, 32'h0002_0000);
    chk("wfi2_awake", 32'(sleep), 32'd0);
    csr(12'h341, NOP, 1'b0, 32'h0, rd, ill);
    chk("wfi2_mepc", rd, 32'h0000_0304);

    // CSR write colliding with trap: write dropped
    csr(12'h304, ASG, 1'b0, 32'h0000_0800, rd, ill);
    csr(12'h300, ASG, 1'b0, 32'h0000_0008, rd, ill);
    ext_irq = 1'b1; trap_pc = 32'h0000_0400;
    csr(12'h300, ASG, 1'b0, 32'h0, rd, ill);
    ext_irq = 1'b0;
    chk("coll_old", rd, 32'h0000_1808);
    chk("coll_redirect", 32'(redirect), 32'd1);
    chk("coll_pc_tgt", redirect_pc, 32'h0002_0000);
    csr(12'h300, NOP, 1'b0, 32'h0, rd, ill);
    chk("coll_mstatus", rd, 32'h0000_1880);
    csr(12'h342, NOP, 1'b0, 32'h0, rd, ill);
    chk("coll_mcause", rd, 32'h8000_000B);
    csr(12'h341, NOP, 1'b0, 32'h0, rd, ill);
    chk("coll_mepc", rd, 32'h0000_0400);

    // Reset while asleep
    @(negedge clk); wfi = 1'b1;
    @(posedge clk); #1; wfi = 1'b0;
    chk("rs_sleep_before", 32'(sleep), 32'd1);
    @(negedge clk); rst = 1'b0; #1;
    chk("rs_sleep", 32'(sleep), 32'd0);
    chk("rs_redirect", 32'(redirect), 32'd0);
    csr_read = 1'b1; csr_addr = 12'h305; #1;
    chk("rs_mtvec", csr_rdata, 32'h0001_0000);
    csr_addr = 12'hB00; #1;
    chk("rs_mcycle", csr_rdata, 32'h0);
    csr_addr = 12'hC82; #1;
    chk("rs_instreth", csr_rdata, 32'h0);
    csr_addr = 12'h342; #1;
    chk("rs_mcause", csr_rdata, 32'h0);
    csr_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    csr(12'h304, NOP, 1'b0, 32'h0, rd, ill);
    chk("rs_mie", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
